show_cmd_sequencer: RTL and testbench

Upstream command sequencer for the overlay draw stage, `show_rect_ascii_single`. It accepts draw commands (clear band, rectangle outline, character) over a valid/ready handshake. It drives the draw stage's parameter inputs, all updated in one cycle, and holds each command for exactly as many cycles as the draw stage's internal scanner needs to finish it. Between commands it drives the no-draw pattern, so software or a higher-level FSM can queue overlays without knowing draw-stage timing.

---
 rtl/show_cmd_sequencer_pkg.sv | 57 +++++
 rtl/show_cmd_sequencer_if.sv | 27 ++
 rtl/show_cmd_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_show_cmd_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/show_cmd_sequencer_pkg.sv
// Shared types and constants for the overlay command sequencer.
package show_cmd_sequencer_pkg;

  localparam int A_W     = 7;   // character code width
  localparam int L_W     = 8;   // overlay coordinate width
  localparam int PHASE_W = 7;   // glyph scan counter width (8x16 cells)
  localparam int HOLD_W  = 17;  // wide enough for a full-screen clear

  localparam logic [1:0] OP_CLEAR = 2'd0;
  localparam logic [1:0] OP_RECT  = 2'd1;
  localparam logic [1:0] OP_CHAR  = 2'd2;

  localparam logic [A_W-1:0] ASCII_CLEAR  = 7'd0;
  localparam logic [A_W-1:0] ASCII_RECT   = 7'd1;
  localparam logic [A_W-1:0] ASCII_NODRAW = 7'd32;

  localparam int GLYPH_CYCLES = 128;
  localparam int DRAIN_CYCLES = 2;
  localparam int CLEAR_LINE   = 256;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_DRAW,
    ST_DRAIN
  } state_e;

  // Command as captured from the handshake.
  typedef struct packed {
    logic [1:0]     op;
    logic [A_W-1:0] ascii;
    logic [2:0]     color;
    logic [L_W-1:0] x1;
    logic [L_W-1:0] y1;
    logic [L_W-1:0] x2;
    logic [L_W-1:0] y2;
  } cmd_t;

  // Parameter set presented to the draw stage.
  typedef struct packed {
    logic [A_W-1:0] ascii;
    logic [2:0]     color;
    logic [L_W-1:0] x;
    logic [L_W-1:0] y;
    logic [L_W-1:0] x1;
    logic [L_W-1:0] y1;
    logic [L_W-1:0] x2;
    logic [L_W-1:0] y2;
    logic [L_W-1:0] ys;
    logic [L_W-1:0] ye;
  } draw_t;

  localparam draw_t DRAW_IDLE = '{ascii: ASCII_NODRAW, color: 3'd0,
                                  x: 8'd0, y: 8'd0, x1: 8'd0, y1: 8'd0,
                                  x2: 8'd0, y2: 8'd0, ys: 8'd0, ye: 8'd0};

endpackage

// File: rtl/show_cmd_sequencer_if.sv
// Command channel between a command source and the sequencer.
interface show_cmd_sequencer_if;
  import show_cmd_sequencer_pkg::*;

  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [A_W-1:0] cmd_ascii;
  logic [2:0]     cmd_color;
  logic [L_W-1:0] cmd_x1;
  logic [L_W-1:0] cmd_y1;
  logic [L_W-1:0] cmd_x2;
  logic [L_W-1:0] cmd_y2;

  modport master (
    output cmd_valid, cmd_op, cmd_ascii, cmd_color,
           cmd_x1, cmd_y1, cmd_x2, cmd_y2,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ascii, cmd_color,
           cmd_x1, cmd_y1, cmd_x2, cmd_y2,
    output cmd_ready
  );

endinterface

// File: rtl/show_cmd_sequencer.sv
// Sequences clear/rect/char commands into the overlay draw stage, holding
// each parameter set for exactly the draw stage's scan time.
module show_cmd_sequencer
  import show_cmd_sequencer_pkg::*;
(
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  show_cmd_sequencer_if.slave  cmd,
  output logic [A_W-1:0]       o_ascii,
  output logic [2:0]           o_color,
  output logic [L_W-1:0]       o_x,
  output logic [L_W-1:0]       o_y,
  output logic [L_W-1:0]       o_x1,
  output logic [L_W-1:0]       o_y1,
  output logic [L_W-1:0]       o_x2,
  output logic [L_W-1:0]       o_y2,
  output logic [L_W-1:0]       o_ys,
  output logic [L_W-1:0]       o_ye,
  output logic                 o_busy,
  output logic                 o_err
);

  // Scan cycles needed by the draw stage for one command.
  function automatic logic [HOLD_W-1:0] hold_count(cmd_t c);
    logic [10:0]       rect_n;
    logic [HOLD_W-1:0] clr_n;
    rect_n = ((({3'b0, c.x2} - {3'b0, c.x1}) + ({3'b0, c.y2} - {3'b0, c.y1})) << 1) + 11'd2;
    // One spare line absorbs whatever phase the scanner is at on entry.
    clr_n  = (({9'b0, c.y2} - {9'b0, c.y1} + 17'd1) << 8) + 17'(CLEAR_LINE);
    case (c.op)
      OP_RECT:  hold_count = {6'b0, rect_n};
      OP_CLEAR: hold_count = clr_n;
      default:  hold_count = 17'(GLYPH_CYCLES);
    endcase
  endfunction

  // Ops 0/1 are encoded as ascii 0/1, so a char using those codes would alias them.
  function automatic logic cmd_legal(cmd_t c);
    case (c.op)
      OP_CHAR:  cmd_legal = (c.ascii > ASCII_RECT);
      OP_RECT:  cmd_legal = (c.x2 >= c.x1) && (c.y2 >= c.y1);
      OP_CLEAR: cmd_legal = (c.y2 >= c.y1);
      default:  cmd_legal = 1'b0;
    endcase
  endfunction

  function automatic draw_t draw_of(cmd_t c);
    draw_t d;
    d = DRAW_IDLE;
    case (c.op)
      OP_CHAR: begin
        d.ascii = c.ascii;
        d.color = c.color;
        d.x     = c.x1;
        d.y     = c.y1;
      end
      OP_RECT: begin
        d.ascii = ASCII_RECT;
        d.color = c.color;
        d.x1    = c.x1;
        d.y1    = c.y1;
        d.x2    = c.x2;
        d.y2    = c.y2;
      end
      default: begin
        d.ascii = ASCII_CLEAR;
        d.ys    = c.y1;
        d.ye    = c.y2;
      end
    endcase
    draw_of = d;
  endfunction

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  cmd_t                lat_q, lat_d;
  draw_t               out_q, out_d;
  logic                err_q, err_d;
  logic                rdy_q, rdy_d;
  logic                busy_q, busy_d;

  cmd_t                cmd_in;
  logic                xfer;

  assign cmd_in = {cmd.cmd_op, cmd.cmd_ascii, cmd.cmd_color,
                   cmd.cmd_x1, cmd.cmd_y1, cmd.cmd_x2, cmd.cmd_y2};
  assign xfer   = cmd.cmd_valid && rdy_q;

  // Next state, hold counter and output parameter set.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q + 7'd1;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    out_d   = out_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (!cmd_legal(cmd_in)) begin
            err_d = 1'b1;
          end else if (cmd_in.op == OP_CHAR) begin
            lat_d   = cmd_in;
            state_d = ST_ALIGN;
          end else begin
            out_d   = draw_of(cmd_in);
            cnt_d   = hold_count(cmd_in);
            state_d = ST_DRAW;
          end
        end
      end
      ST_ALIGN: begin
        // Load on the last phase so the glyph is presented at phase 0.
        if (phase_q == 7'd127) begin
          out_d   = draw_of(lat_q);
          cnt_d   = 17'(GLYPH_CYCLES);
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (cnt_q == 17'd1) begin
          out_d   = DRAW_IDLE;
          cnt_d   = 17'(DRAIN_CYCLES);
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
      default: begin
        // Idle pattern flushes the draw stage's internal pipeline.
        if (cnt_q == 17'd1) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 17'd1;
        end
      end
    endcase
    rdy_d  = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
  end

  // State registers; reset aborts any command and restores idle outputs.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      out_q   <= DRAW_IDLE;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      out_q   <= out_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd.cmd_ready = rdy_q;
  assign o_ascii = out_q.ascii;
  assign o_color = out_q.color;
  assign o_x     = out_q.x;
  assign o_y     = out_q.y;
  assign o_x1    = out_q.x1;
  assign o_y1    = out_q.y1;
  assign o_x2    = out_q.x2;
  assign o_y2    = out_q.y2;
  assign o_ys    = out_q.ys;
  assign o_ye    = out_q.ye;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_show_cmd_sequencer.sv
// Random + directed command stream checked every cycle against a
// timeline model (draw window, ready time, error pulse).
module tb_show_cmd_sequencer;
  import show_cmd_sequencer_pkg::*;

  logic           sys_clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic [A_W-1:0] o_ascii;
  logic [2:0]     o_color;
  logic [L_W-1:0] o_x, o_y, o_x1, o_y1, o_x2, o_y2, o_ys, o_ye;
  logic           o_busy, o_err;

  show_cmd_sequencer_if cmd_if ();

  show_cmd_sequencer dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cmd     (cmd_if.slave),
    .o_ascii (o_ascii),
    .o_color (o_color),
    .o_x     (o_x),
    .o_y     (o_y),
    .o_x1    (o_x1),
    .o_y1    (o_y1),
    .o_x2    (o_x2),
    .o_y2    (o_y2),
    .o_ys    (o_ys),
    .o_ye    (o_ye),
    .o_busy  (o_busy),
    .o_err   (o_err)
  );

  always #5 sys_clk = ~sys_clk;

  localparam logic [73:0] IDLE_VEC = {7'd32, 67'b0};

  logic [73:0] act_vec;
  assign act_vec = {o_ascii, o_color, o_x, o_y, o_x1, o_y1, o_x2, o_y2, o_ys, o_ye};

  int n_chk = 0;
  int n_err = 0;

  // Timeline model: cycle index since reset release equals the scan phase.
  int          cyc = 0;
  int          ready_at = 0;
  int          draw_start = 0;
  int          draw_end = 0;
  int          err_at = -1;
  logic [73:0] draw_vec = IDLE_VEC;

  task automatic chk(input string tag, input logic [79:0] act, input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit legal(cmd_t c);
    if (c.op == 2'd3) return 0;
    if (c.op == 2'd2) return c.ascii >= 7'd2;
    if (c.op == 2'd1) return (c.x2 >= c.x1) && (c.y2 >= c.y1);
    return c.y2 >= c.y1;
  endfunction

  function automatic int hold_of(cmd_t c);
    if (c.op == 2'd2) return 128;
    if (c.op == 2'd1) return 2 * ((int'(c.x2) - int'(c.x1)) + (int'(c.y2) - int'(c.y1))) + 2;
    return (int'(c.y2) - int'(c.y1) + 1) * 256 + 256;
  endfunction

  function automatic logic [73:0] vec_of(cmd_t c);
    if (c.op == 2'd2) return {c.ascii, c.color, c.x1, c.y1, 48'b0};
    if (c.op == 2'd1) return {7'd1, c.color, 16'b0, c.x1, c.y1, c.x2, c.y2, 16'b0};
    return {7'd0, 3'b0, 48'b0, c.y1, c.y2};
  endfunction

  // Command accepted in cycle k: schedule its draw window.
  task automatic model_accept(input cmd_t c, input int k);
    int start;
    if (!legal(c)) begin
      err_at = k + 1;
    end else begin
      start      = (c.op == 2'd2) ? ((k + 1) / 128 + 1) * 128 : k + 1;
      draw_start = start;
      draw_end   = start + hold_of(c);
      ready_at   = draw_end + 2;
      draw_vec   = vec_of(c);
    end
  endtask

  task automatic check_cycle();
    bit          rdy, err;
    logic [73:0] exp_out;
    rdy     = (cyc >= ready_at);
    err     = (cyc == err_at);
    exp_out = (cyc >= draw_start && cyc < draw_end) ? draw_vec : IDLE_VEC;
    chk("ctl{ready,busy,err}", 80'({cmd_if.cmd_ready, o_busy, o_err}), 80'({rdy, !rdy, err}));
    chk("params", 80'(act_vec), 80'(exp_out));
  endtask

  task automatic step();
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
  endtask

  task automatic drive(input cmd_t c);
    cmd_if.cmd_op    = c.op;
    cmd_if.cmd_ascii = c.ascii;
    cmd_if.cmd_color = c.color;
    cmd_if.cmd_x1    = c.x1;
    cmd_if.cmd_y1    = c.y1;
    cmd_if.cmd_x2    = c.x2;
    cmd_if.cmd_y2    = c.y2;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op = 2'($urandom_range(0, 3));
    if (c.op == 2'd3 && $urandom_range(0, 3) != 0) c.op = 2'($urandom_range(0, 2));
    c.ascii = 7'($urandom_range(0, 127));
    if (c.op == 2'd2 && $urandom_range(0, 7) == 0) c.ascii = 7'($urandom_range(0, 1));
    c.color = 3'($urandom);
    c.x1 = 8'($urandom_range(1, 200));
    c.y1 = 8'($urandom_range(1, 200));
    c.x2 = c.x1 + 8'($urandom_range(0, 50));
    c.y2 = c.y1 + 8'((c.op == 2'd0) ? $urandom_range(0, 5) : $urandom_range(0, 50));
    if ($urandom_range(0, 5) == 0) begin
      if ($urandom_range(0, 1) == 0) c.x2 = c.x1 - 8'd1;
      else                           c.y2 = c.y1 - 8'd1;
    end
    return c;
  endfunction

  // Idle cycles with random, unqualified data on the bus.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      check_cycle();
      cmd_if.cmd_valid = 1'b0;
      drive(rand_cmd());
      step();
    end
  endtask

  // Offer c (optionally only in a given phase) until the model accepts it.
  task automatic offer(input cmd_t c, input int at_phase);
    bit accepted = 0;
    drive(c);
    for (int i = 0; i < 5000 && !accepted; i++) begin
      check_cycle();
      cmd_if.cmd_valid = (at_phase < 0) || ((cyc % 128) == at_phase);
      if (cmd_if.cmd_valid && cyc >= ready_at) begin
        model_accept(c, cyc);
        accepted = 1;
      end
      step();
      cmd_if.cmd_valid = 1'b0;
    end
    chk("accept_bound", 80'(accepted), 80'(1));
  endtask

  function automatic cmd_t mk(input logic [1:0] op, input logic [6:0] a, input logic [2:0] col,
                              input logic [7:0] x1, input logic [7:0] y1,
                              input logic [7:0] x2, input logic [7:0] y2);
    cmd_t c;
    c = {op, a, col, x1, y1, x2, y2};
    return c;
  endfunction

  initial begin
    cmd_if.cmd_valid = 1'b0;
    drive(mk(2'd0, 7'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd0));
    repeat (3) @(negedge sys_clk);
    check_cycle();                      // outputs idle while in reset
    sys_rst = 1'b0;
    cyc = 0;

    idle(200);

    offer(mk(2'd2, 7'd65, 3'b100, 8'd10, 8'd20, 8'd0, 8'd0), 50);   // 'A'
    offer(mk(2'd1, 7'd0, 3'b010, 8'd5, 8'd5, 8'd9, 8'd7), -1);      // 14-cycle outline
    offer(mk(2'd0, 7'd0, 3'b111, 8'd0, 8'd0, 8'd0, 8'd3), -1);      // 1280-cycle clear
    offer(mk(2'd1, 7'd0, 3'b001, 8'd5, 8'd5, 8'd4, 8'd7), -1);      // reject x2<x1
    offer(mk(2'd2, 7'd1, 3'b001, 8'd1, 8'd1, 8'd0, 8'd0), -1);      // reject ascii 1
    offer(mk(2'd3, 7'd65, 3'b001, 8'd1, 8'd1, 8'd2, 8'd2), -1);     // reject op 3
    offer(mk(2'd2, 7'd66, 3'b011, 8'd3, 8'd4, 8'd0, 8'd0), 127);    // longest align
    offer(mk(2'd2, 7'd67, 3'b011, 8'd3, 8'd4, 8'd0, 8'd0), 126);    // shortest align
    idle(4);

    for (int n = 0; n < 30; n++) begin
      offer(rand_cmd(), ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 127)) : -1);
      idle($urandom_range(0, 3));
    end

    // Reset during a clear's draw window.
    offer(mk(2'd0, 7'd0, 3'd0, 8'd0, 8'd0, 8'd0, 8'd3), -1);
    idle(300);
    #2 sys_rst = 1'b1;
    #1;
    ready_at = 0; draw_start = 0; draw_end = 0; err_at = -1;
    check_cycle();
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_cycle();
    sys_rst = 1'b0;
    cyc = 0;
    idle(20);
    offer(mk(2'd2, 7'd65, 3'b100, 8'd10, 8'd20, 8'd0, 8'd0), 50);
    idle(300);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
